// File: rtl/dmem_atomic_ctrl_pkg.sv
// Shared types for the data-side memory controller: RAM handshake states,
// controller FSM states, request kinds and the SC result encodings.
package dmem_atomic_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        SCF  = 3'd3,
        DONE = 3'd4
    } dmem_state_t;

    typedef enum logic [1:0] {
        OP_LW = 2'd0,
        OP_SW = 2'd1,
        OP_LL = 2'd2,
        OP_SC = 2'd3
    } dmem_op_t;

    localparam word_t SC_PASS = 32'd1;
    localparam word_t SC_FAIL = 32'd0;

    // REN wins over WEN; datomic turns a read into LL and a write into SC.
    function automatic dmem_op_t decodeOp(input logic ren, input logic atomic);
        if (ren) begin
            return atomic ? OP_LL : OP_LW;
        end
        return atomic ? OP_SC : OP_SW;
    endfunction

endpackage

// File: rtl/dmem_atomic_ctrl_link_reg.sv
// LL/SC link register: holds the linked word address and valid bit, decides
// whether an SC presented this cycle may pass, and applies link updates in
// priority order (halt, snoop hit, SC/SW completion, LL completion).
module dmem_atomic_ctrl_link_reg
    import dmem_atomic_ctrl_pkg::*;
#(
    parameter int OFF_BITS = 2
)
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_halt,
    input  logic  i_snoopValid,
    input  word_t i_snoopAddr,
    input  word_t i_checkAddr,
    input  word_t i_doneAddr,
    input  logic  i_llDone,
    input  logic  i_scDone,
    input  logic  i_swDone,
    output logic  o_scPass
);

    word_t r_linkAddr;
    logic  r_linkValid;

    logic  w_snoopHit;
    logic  w_swHit;
    logic  w_checkHit;

    // Two byte addresses name the same word when they differ only in the offset bits.
    function automatic logic sameWord(input word_t a, input word_t b);
        return ((a ^ b) >> OFF_BITS) == '0;
    endfunction

    // Address compares; an SC passes only if the link survives this cycle's halt and snoop.
    always_comb begin
        w_snoopHit = i_snoopValid & sameWord(i_snoopAddr, r_linkAddr);
        w_swHit    = i_swDone & sameWord(i_doneAddr, r_linkAddr);
        w_checkHit = sameWord(i_checkAddr, r_linkAddr);
        o_scPass   = r_linkValid & w_checkHit & ~i_halt & ~w_snoopHit;
    end

    // Link update: clearing events outrank a completing LL, so a halt or a hit snoop always wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_linkAddr  <= '0;
            r_linkValid <= 1'b0;
        end else if (i_halt) begin
            r_linkValid <= 1'b0;
        end else if (w_snoopHit) begin
            r_linkValid <= 1'b0;
        end else if (i_scDone || w_swHit) begin
            r_linkValid <= 1'b0;
        end else if (i_llDone) begin
            r_linkAddr  <= i_doneAddr;
            r_linkValid <= 1'b1;
        end
    end

endmodule

// File: rtl/dmem_atomic_ctrl.sv
// Data-side memory responder: accepts LW/SW/LL/SC from the datapath, drives the
// RAM handshake, and returns a one-cycle dhit with the load data or SC result.
// Optional macro DMEM_ERR_EN: a RAM ERROR ends the access with derr; without it
// ERROR is retried like BUSY and derr stays low.
module dmem_atomic_ctrl
    import dmem_atomic_ctrl_pkg::*;
#(
    parameter int OFF_BITS    = 2,
    parameter int SC_FAIL_LAT = 1
)
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      dmemREN,
    input  logic      dmemWEN,
    input  logic      datomic,
    input  word_t     dmemaddr,
    input  word_t     dmemstore,
    input  logic      halt,
    input  logic      ccinv,
    input  word_t     ccsnoopaddr,
    output logic      dhit,
    output word_t     dmemload,
    output logic      derr,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam logic [1:0] SCF_LAST = 2'(SC_FAIL_LAT - 1);

    dmem_state_t r_state;
    dmem_state_t w_nextState;

    word_t       r_addr;
    word_t       r_store;
    word_t       r_data;
    dmem_op_t    r_op;
    logic        r_scOk;
    logic        r_err;
    logic [1:0]  r_cnt;

    logic        w_accept;
    logic        w_scPass;
    logic        w_done;
    logic        w_ramErr;
    logic        w_llDone;
    logic        w_scDone;
    logic        w_swDone;

    assign w_accept = (r_state == IDLE) & (dmemREN | dmemWEN);
    assign w_done   = (r_state == DONE);

`ifdef DMEM_ERR_EN
    assign w_ramErr = ((r_state == RD) | (r_state == WR)) & (ramstate == ERROR);
`else
    assign w_ramErr = 1'b0;
`endif

    assign w_llDone = w_done & (r_op == OP_LL) & ~r_err;
    assign w_scDone = w_done & (r_op == OP_SC) & r_scOk;
    assign w_swDone = w_done & (r_op == OP_SW);

    assign dmemload = r_data;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;

    dmem_atomic_ctrl_link_reg #(
        .OFF_BITS(OFF_BITS)
    ) u_linkReg (
        .i_clk        (CLK),
        .i_rst_n      (nRST),
        .i_halt       (halt),
        .i_snoopValid (ccinv),
        .i_snoopAddr  (ccsnoopaddr),
        .i_checkAddr  (dmemaddr),
        .i_doneAddr   (r_addr),
        .i_llDone     (w_llDone),
        .i_scDone     (w_scDone),
        .i_swDone     (w_swDone),
        .o_scPass     (w_scPass)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: pick the path on acceptance, wait on the RAM, count out failed SCs.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (dmemREN) begin
                    w_nextState = RD;
                end else if (dmemWEN) begin
                    if (!datomic || w_scPass) begin
                        w_nextState = WR;
                    end else begin
                        w_nextState = SCF;
                    end
                end
            end
            RD, WR: begin
                if (ramstate == ACCESS || w_ramErr) begin
                    w_nextState = DONE;
                end
            end
            SCF: begin
                if (r_cnt == SCF_LAST) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs decoded from state: strobes while waiting on RAM, dhit for the single DONE cycle.
    always_comb begin
        ramREN = (r_state == RD);
        ramWEN = (r_state == WR);
        dhit   = (r_state == DONE);
`ifdef DMEM_ERR_EN
        derr   = (r_state == DONE) & r_err;
`else
        derr   = 1'b0;
`endif
    end

    // Request latches: address/data/kind on acceptance, then the result as the access finishes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_addr  <= '0;
            r_store <= '0;
            r_data  <= '0;
            r_op    <= OP_LW;
            r_scOk  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_addr  <= dmemaddr;
            r_store <= dmemstore;
            r_op    <= decodeOp(dmemREN, datomic);
            r_scOk  <= ~dmemREN & datomic & w_scPass;
            r_data  <= (~dmemREN & datomic & w_scPass) ? SC_PASS : SC_FAIL;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_ramErr) begin
            r_data  <= SC_FAIL;
            r_err   <= 1'b1;
        end else if (r_state == RD && ramstate == ACCESS) begin
            r_data  <= ramload;
        end else if (r_state == SCF) begin
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_dmem_atomic_ctrl.sv
// Self-checking bench for dmem_atomic_ctrl: a vector table of LW/SW/LL/SC
// requests, hand-written corner sequences (snoops, halt, RAM errors, reset
// mid-access), and a randomized run checked against a word-level memory/link model.
module tb_dmem_atomic_ctrl;
   import dmem_atomic_ctrl_pkg::*;

   localparam int SC_FAIL_LAT = 2;
   localparam int SCF_LAT     = SC_FAIL_LAT + 1;
   localparam int MAX_WAIT    = 60;

   logic      CLK;
   logic      nRST;
   logic      dmemREN;
   logic      dmemWEN;
   logic      datomic;
   word_t     dmemaddr;
   word_t     dmemstore;
   logic      halt;
   logic      ccinv;
   word_t     ccsnoopaddr;
   logic      dhit;
   word_t     dmemload;
   logic      derr;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   int checks = 0;
   int fails = 0;

   int ramLatency = 0;
   int ramErrCycles = 0;
   int writeCount = 0;
   word_t lastWAddr;
   word_t lastWData;
   word_t envMem [256];

   word_t refMem [256];
   logic refLinkValid;
   logic [29:0] refLinkWord;

   typedef struct {
      logic  ren;
      logic  wen;
      logic  atomic;
      word_t addr;
      word_t store;
      int    lat;
      logic  chkLoad;
      word_t expLoad;
      logic  expErr;
      int    expLat;
      int    expWrites;
      int    expStrobes;
   } vec_t;

   vec_t vecs [13];

   int kind;
   word_t rAddr;
   word_t rData;
   int rLat;
   logic rPass;
   int widx;
   logic sawHit;

   dmem_atomic_ctrl #(
      .OFF_BITS(2),
      .SC_FAIL_LAT(SC_FAIL_LAT)
   ) dut (
      .CLK(CLK),
      .nRST(nRST),
      .dmemREN(dmemREN),
      .dmemWEN(dmemWEN),
      .datomic(datomic),
      .dmemaddr(dmemaddr),
      .dmemstore(dmemstore),
      .halt(halt),
      .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr),
      .dhit(dhit),
      .dmemload(dmemload),
      .derr(derr),
      .ramREN(ramREN),
      .ramWEN(ramWEN),
      .ramaddr(ramaddr),
      .ramstore(ramstore),
      .ramload(ramload),
      .ramstate(ramstate)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // RAM model: ramErrCycles ERRORs, then ramLatency BUSYs, then ACCESS on the word addressed
   initial begin
      int busyLeft;
      int errLeft;
      logic inAccess;
      ramstate = FREE;
      ramload = '0;
      inAccess = 1'b0;
      busyLeft = 0;
      errLeft = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (!nRST) begin
            inAccess = 1'b0;
            ramstate = FREE;
         end else if (ramREN || ramWEN) begin
            if (!inAccess) begin
               inAccess = 1'b1;
               busyLeft = ramLatency;
               errLeft = ramErrCycles;
            end
            if (errLeft > 0) begin
               ramstate = ERROR;
               errLeft--;
            end else if (busyLeft > 0) begin
               ramstate = BUSY;
               busyLeft--;
            end else begin
               ramstate = ACCESS;
               inAccess = 1'b0;
               if (ramREN) begin
                  ramload = envMem[ramaddr[9:2]];
               end else begin
                  envMem[ramaddr[9:2]] = ramstore;
                  writeCount++;
                  lastWAddr = ramaddr;
                  lastWData = ramstore;
               end
            end
         end else begin
            ramstate = FREE;
            inAccess = 1'b0;
         end
      end
   end

   // Hard stop in case something wedges the main sequence
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input word_t actual, input word_t expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic vec_t mkVec(input logic ren, input logic wen, input logic atomic,
                                  input word_t addr, input word_t store, input int lat,
                                  input logic chkLoad, input word_t expLoad, input logic expErr,
                                  input int expLat, input int expWrites, input int expStrobes);
      vec_t v;
      v.ren = ren;
      v.wen = wen;
      v.atomic = atomic;
      v.addr = addr;
      v.store = store;
      v.lat = lat;
      v.chkLoad = chkLoad;
      v.expLoad = expLoad;
      v.expErr = expErr;
      v.expLat = expLat;
      v.expWrites = expWrites;
      v.expStrobes = expStrobes;
      return v;
   endfunction

   // Drive one request until dhit (bounded), optionally pulsing a snoop in cycle snoopCyc
   task automatic applyStimulus(input logic ren, input logic wen, input logic atomic,
                                input word_t addr, input word_t data,
                                input int snoopCyc, input word_t snoopA,
                                output word_t load, output int lat, output logic err,
                                output int strobes, output logic hitAfter);
      lat = -1;
      load = '0;
      err = 1'b0;
      strobes = 0;
      @(posedge CLK);
      #1;
      dmemREN = ren;
      dmemWEN = wen;
      datomic = atomic;
      dmemaddr = addr;
      dmemstore = data;
      for (int c = 0; c < MAX_WAIT; c++) begin
         ccinv = (c == snoopCyc);
         ccsnoopaddr = snoopA;
         @(negedge CLK);
         if (ramREN || ramWEN) strobes++;
         if (dhit) begin
            lat = c;
            load = dmemload;
            err = derr;
            break;
         end
         @(posedge CLK);
         #1;
      end
      @(posedge CLK);
      #1;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      datomic = 1'b0;
      ccinv = 1'b0;
      @(negedge CLK);
      hitAfter = dhit;
   endtask

   task automatic runAndCheck(input string name, input vec_t v, input int snoopCyc, input word_t snoopA);
      word_t load;
      int lat;
      logic err;
      int strobes;
      logic hitAfter;
      int wBefore;
      wBefore = writeCount;
      ramLatency = v.lat;
      applyStimulus(v.ren, v.wen, v.atomic, v.addr, v.store, snoopCyc, snoopA,
                    load, lat, err, strobes, hitAfter);
      checkOutput({name, " latency"}, word_t'(lat), word_t'(v.expLat));
      if (v.chkLoad) checkOutput({name, " dmemload"}, load, v.expLoad);
      checkOutput({name, " derr"}, {31'd0, err}, {31'd0, v.expErr});
      checkOutput({name, " dhit width"}, {31'd0, hitAfter}, 32'd0);
      checkOutput({name, " ram writes"}, word_t'(writeCount - wBefore), word_t'(v.expWrites));
      if (v.expStrobes >= 0) checkOutput({name, " strobe cycles"}, word_t'(strobes), word_t'(v.expStrobes));
      if (v.expWrites > 0) begin
         checkOutput({name, " write addr"}, lastWAddr, v.addr);
         checkOutput({name, " write data"}, lastWData, v.store);
      end
   endtask

   task automatic pulseHalt();
      @(posedge CLK);
      #1;
      halt = 1'b1;
      @(posedge CLK);
      #1;
      halt = 1'b0;
      @(negedge CLK);
   endtask

   task automatic pulseSnoop(input word_t a);
      @(posedge CLK);
      #1;
      ccinv = 1'b1;
      ccsnoopaddr = a;
      @(posedge CLK);
      #1;
      ccinv = 1'b0;
      @(negedge CLK);
   endtask

   // Main sequence: reset, vector table, corner sequences, then randomized traffic
   initial begin
      nRST = 1'b0;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      datomic = 1'b0;
      dmemaddr = '0;
      dmemstore = '0;
      halt = 1'b0;
      ccinv = 1'b0;
      ccsnoopaddr = '0;
      lastWAddr = '0;
      lastWData = '0;
      for (int i = 0; i < 256; i++) envMem[i] = 32'hA500_0000 | word_t'(i);
      envMem[32'h100 >> 2] = 32'hDEAD_BEEF;
      envMem[32'h200 >> 2] = 32'h1111_2222;

      repeat (3) @(negedge CLK);
      checkOutput("reset dhit/derr/ramREN/ramWEN", {28'd0, dhit, derr, ramREN, ramWEN}, 32'd0);
      checkOutput("reset dmemload", dmemload, 32'd0);
      checkOutput("reset ramaddr", ramaddr, 32'd0);
      checkOutput("reset ramstore", ramstore, 32'd0);
      nRST = 1'b1;
      repeat (2) @(negedge CLK);

      vecs[0]  = mkVec(1, 0, 0, 32'h100, 32'h0,  3, 1, 32'hDEAD_BEEF, 0, 5, 0, 4);
      vecs[1]  = mkVec(1, 0, 1, 32'h200, 32'h0,  0, 1, 32'h1111_2222, 0, 2, 0, 1);
      vecs[2]  = mkVec(0, 1, 1, 32'h200, 32'h5,  0, 1, 32'd1, 0, 2, 1, 1);
      vecs[3]  = mkVec(0, 1, 1, 32'h200, 32'h6,  0, 1, 32'd0, 0, SCF_LAT, 0, 0);
      vecs[4]  = mkVec(1, 0, 0, 32'h200, 32'h0,  1, 1, 32'h5, 0, 3, 0, 2);
      vecs[5]  = mkVec(1, 0, 1, 32'h200, 32'h0,  0, 1, 32'h5, 0, 2, 0, 1);
      vecs[6]  = mkVec(0, 1, 0, 32'h202, 32'h7,  2, 0, 32'h0, 0, 4, 1, 3);
      vecs[7]  = mkVec(0, 1, 1, 32'h200, 32'h8,  0, 1, 32'd0, 0, SCF_LAT, 0, 0);
      vecs[8]  = mkVec(1, 0, 1, 32'h200, 32'h0,  0, 1, 32'h7, 0, 2, 0, 1);
      vecs[9]  = mkVec(0, 1, 0, 32'h204, 32'h9,  0, 0, 32'h0, 0, 2, 1, 1);
      vecs[10] = mkVec(0, 1, 1, 32'h200, 32'hA,  0, 1, 32'd1, 0, 2, 1, 1);
      vecs[11] = mkVec(1, 1, 0, 32'h204, 32'h55, 0, 1, 32'h9, 0, 2, 0, 1);
      vecs[12] = mkVec(1, 0, 0, 32'h200, 32'h0,  0, 1, 32'hA, 0, 2, 0, 1);

      for (int i = 0; i < 13; i++) begin
         runAndCheck($sformatf("vec%0d", i), vecs[i], -1, 32'h0);
      end

      runAndCheck("snoopSC LL", mkVec(1, 0, 1, 32'h300, 0, 0, 1, 32'hA500_00C0, 0, 2, 0, 1), -1, 0);
      runAndCheck("snoopSC SC", mkVec(0, 1, 1, 32'h300, 32'h77, 0, 1, 32'd0, 0, SCF_LAT, 0, 0), 0, 32'h300);

      runAndCheck("otherSnoop LL", mkVec(1, 0, 1, 32'h300, 0, 0, 0, 0, 0, 2, 0, 1), -1, 0);
      runAndCheck("otherSnoop SC", mkVec(0, 1, 1, 32'h300, 32'h66, 0, 1, 32'd1, 0, 2, 1, 1), 0, 32'h304);

      runAndCheck("lateSnoop LL", mkVec(1, 0, 1, 32'h300, 0, 0, 1, 32'h66, 0, 2, 0, 1), -1, 0);
      runAndCheck("lateSnoop SC", mkVec(0, 1, 1, 32'h300, 32'h88, 3, 1, 32'd1, 0, 5, 1, 4), 2, 32'h300);

      runAndCheck("halt LL", mkVec(1, 0, 1, 32'h300, 0, 0, 1, 32'h88, 0, 2, 0, 1), -1, 0);
      pulseHalt();
      runAndCheck("halt SC", mkVec(0, 1, 1, 32'h300, 32'h99, 0, 1, 32'd0, 0, SCF_LAT, 0, 0), -1, 0);

      ramErrCycles = 2;
`ifdef DMEM_ERR_EN
      runAndCheck("err LL", mkVec(1, 0, 1, 32'h308, 0, 0, 1, 32'd0, 1, 2, 0, 1), -1, 0);
      ramErrCycles = 0;
      runAndCheck("err SC", mkVec(0, 1, 1, 32'h308, 32'h12, 0, 1, 32'd0, 0, SCF_LAT, 0, 0), -1, 0);
`else
      runAndCheck("err LL", mkVec(1, 0, 1, 32'h308, 0, 0, 1, 32'hA500_00C2, 0, 4, 0, 3), -1, 0);
      ramErrCycles = 0;
      runAndCheck("err SC", mkVec(0, 1, 1, 32'h308, 32'h12, 0, 1, 32'd1, 0, 2, 1, 1), -1, 0);
`endif

      runAndCheck("rstLink LL", mkVec(1, 0, 1, 32'h30C, 0, 0, 1, 32'hA500_00C3, 0, 2, 0, 1), -1, 0);
      ramLatency = 10;
      @(posedge CLK);
      #1;
      dmemREN = 1'b1;
      datomic = 1'b0;
      dmemaddr = 32'h100;
      repeat (3) @(negedge CLK);
      checkOutput("midRd ramREN", {31'd0, ramREN}, 32'd1);
      #2;
      nRST = 1'b0;
      #1;
      checkOutput("midRd reset strobes/dhit/derr", {28'd0, dhit, derr, ramREN, ramWEN}, 32'd0);
      checkOutput("midRd reset dmemload", dmemload, 32'd0);
      checkOutput("midRd reset ramaddr", ramaddr, 32'd0);
      checkOutput("midRd reset ramstore", ramstore, 32'd0);
      dmemREN = 1'b0;
      sawHit = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (dhit) sawHit = 1'b1;
      end
      nRST = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         if (dhit || ramREN || ramWEN) sawHit = 1'b1;
      end
      checkOutput("midRd no dhit after reset", {31'd0, sawHit}, 32'd0);
      runAndCheck("rstLink SC", mkVec(0, 1, 1, 32'h30C, 32'h34, 0, 1, 32'd0, 0, SCF_LAT, 0, 0), -1, 0);

      for (int i = 0; i < 256; i++) refMem[i] = envMem[i];
      refLinkValid = 1'b0;
      refLinkWord = '0;
      for (int n = 0; n < 150; n++) begin
         kind = int'($urandom_range(0, 5));
         rAddr = 32'h200 + 32'd4 * $urandom_range(0, 3) + $urandom_range(0, 3);
         rData = $urandom;
         rLat = int'($urandom_range(0, 3));
         widx = int'(rAddr[9:2]);
         if (kind == 5) begin
            if ($urandom_range(0, 1) == 1) begin
               pulseHalt();
               refLinkValid = 1'b0;
            end else begin
               pulseSnoop(rAddr);
               if (rAddr[31:2] == refLinkWord) refLinkValid = 1'b0;
            end
         end else if (kind == 0) begin
            runAndCheck($sformatf("rnd%0d LW", n), mkVec(1, 0, 0, rAddr, rData, rLat, 1, refMem[widx], 0, rLat + 2, 0, rLat + 1), -1, 0);
         end else if (kind == 1) begin
            runAndCheck($sformatf("rnd%0d SW", n), mkVec(0, 1, 0, rAddr, rData, rLat, 0, 0, 0, rLat + 2, 1, rLat + 1), -1, 0);
            refMem[widx] = rData;
            if (rAddr[31:2] == refLinkWord) refLinkValid = 1'b0;
         end else if (kind == 2) begin
            runAndCheck($sformatf("rnd%0d LL", n), mkVec(1, 0, 1, rAddr, rData, rLat, 1, refMem[widx], 0, rLat + 2, 0, rLat + 1), -1, 0);
            refLinkValid = 1'b1;
            refLinkWord = rAddr[31:2];
         end else begin
            rPass = refLinkValid && (rAddr[31:2] == refLinkWord);
            if (rPass) begin
               runAndCheck($sformatf("rnd%0d SC", n), mkVec(0, 1, 1, rAddr, rData, rLat, 1, 32'd1, 0, rLat + 2, 1, rLat + 1), -1, 0);
               refMem[widx] = rData;
               refLinkValid = 1'b0;
            end else begin
               runAndCheck($sformatf("rnd%0d SC", n), mkVec(0, 1, 1, rAddr, rData, rLat, 1, 32'd0, 0, SCF_LAT, 0, 0), -1, 0);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
